// File: rtl/cc_fill_deserializer.sv
// cc_fill_deserializer: collects one AXI R burst of BEATS beats into a cache
// line, starting at the critical-word offset popped from a show-ahead FIFO
// (wrapping modulo BEATS), then pushes the whole line into a line FIFO.
// Optional macro CC_FILL_LAST_CHECK_EN enables a sticky rlast framing check
// on err_o. When the macro is undefined, rlast is ignored and err_o stays 0.
module cc_fill_deserializer #(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BEAT_W-1:0]             mem_rdata_i,
  input  logic                          mem_rlast_i,
  input  logic                          mem_rvalid_i,
  output logic                          mem_rready_o,
  input  logic                          ofs_empty_i,
  input  logic [((BEATS>1)?$clog2(BEATS):1)-1:0] ofs_rdata_i,
  output logic                          ofs_rden_o,
  input  logic                          line_afull_i,
  output logic                          line_wren_o,
  output logic [BEAT_W*BEATS-1:0]       line_wdata_o,
  output logic                          err_o
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PUSH} state_t;

  state_t                         r_state;
  logic [CW-1:0]                  r_ofs;
  logic [CW-1:0]                  r_cnt;
  logic [BEATS-1:0][BEAT_W-1:0]   r_line;
  logic                           r_rready;

  logic                           w_hs;
  logic                           w_last;
  logic [CW-1:0]                  w_slot;

  // Strobes are masked while rst is high so nothing leaks out during reset.
  assign mem_rready_o = r_rready && !rst;
  assign ofs_rden_o   = (r_state == S_IDLE) && !ofs_empty_i && !rst;
  assign line_wren_o  = (r_state == S_PUSH) && !line_afull_i && !rst;
  assign line_wdata_o = r_line;

  assign w_hs   = mem_rvalid_i && mem_rready_o;
  assign w_last = (r_cnt == LAST_CNT);
  // The CW-bit add wraps naturally modulo BEATS (power of two).
  assign w_slot = r_ofs + r_cnt;

  // Main FSM: the offset pop, beat collection and line push; rready is a registered copy of state==COLLECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ofs    <= '0;
      r_cnt    <= '0;
      r_line   <= '0;
      r_rready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!ofs_empty_i) begin
            r_ofs    <= ofs_rdata_i;
            r_cnt    <= '0;
            r_state  <= S_COLLECT;
            r_rready <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (w_hs) begin
            r_line[w_slot] <= mem_rdata_i;
            if (w_last) begin
              r_cnt    <= '0;
              r_state  <= S_PUSH;
              r_rready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_PUSH: begin
          if (!line_afull_i) r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_rready <= 1'b0;
        end
      endcase
    end
  end

`ifdef CC_FILL_LAST_CHECK_EN
  logic r_err;
  assign err_o = r_err;

  // Sticky framing error: rlast must appear on exactly the final counted beat.
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_hs && (mem_rlast_i != w_last))
      r_err <= 1'b1;
  end
`else
  logic w_unused_rlast;
  assign w_unused_rlast = mem_rlast_i;
  assign err_o = 1'b0;
`endif

endmodule
